mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 32, number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  in  1  access request present.
REQ-005 SHALL have port req_ready  out  1  unit can accept a request this cycle.
REQ-006 SHALL have port req_op  in  3  000 LB, 001 LH, 010 LW, 011 SB, 100 LBU, 101 LHU, 110 SH, 111 SW.
REQ-007 SHALL have port req_addr  in  32  byte address.
REQ-008 SHALL have port req_wdata  in  32  store data, right-aligned for SB/SH.
REQ-009 SHALL have port rsp_valid  out  1  response present; held until rsp_ready.
REQ-010 SHALL have port rsp_ready  in  1  consumer accepts response.
REQ-011 SHALL have port rsp_rdata  out  32  load result, extended; 0 for stores and faults.
REQ-012 SHALL have port rsp_fault  out  1  misaligned or out-of-range access.
REQ-013 SHALL have port mem_addr  out  32  word index to data memory address input.
REQ-014 SHALL have port mem_wdata  out  32  full word to data memory write-data input.
REQ-015 SHALL have port mem_we  out  1  data memory write enable; memory commits on negedge of the same cycle.
REQ-016 SHALL have port mem_rdata  in  32  data memory combinational read data for mem_addr.

Function
REQ-017 SHALL implement states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-018 SHALL, in IDLE on req_valid, latch op, address, wdata and compute word index = req_addr[31:2].
REQ-019 SHALL flag fault when LH/LHU/SH has addr[0]=1, LW/SW has addr[1:0]!=0, or word index >= MEM_WORDS; fault goes IDLE->RESP with no memory access.
REQ-020 SHALL transition: loads IDLE->READ->RESP; SW IDLE->WRITE->RESP; SB/SH IDLE->READ->WRITE->RESP (read-modify-write).
REQ-021 SHALL drive mem_addr = latched word index in READ and WRITE, 0 otherwise; mem_we = 1 only in WRITE, decoded from state.
REQ-022 SHALL use big-endian lanes: byte offset 0 = bits [31:24], halfword offset 0 = bits [31:16].
REQ-023 SHALL, at end of READ, sample mem_rdata; loads: select lane, sign-extend (LB/LH) or zero-extend (LBU/LHU); SB/SH: replace only the addressed lane with req_wdata[7:0]/[15:0] into mem_wdata.
REQ-024 SHALL, for SW, drive mem_wdata = latched req_wdata unchanged.
REQ-025 SHALL latency from accept edge to rsp_valid: fault 1, LW/LB/LBU/LH/LHU 2, SW 2, SB/SH 3 cycles.
REQ-026 SHALL hold RESP, rsp_rdata, rsp_fault stable while rsp_valid=1 and rsp_ready=0; return to IDLE on the edge where rsp_ready=1.
REQ-027 SHALL not accept a new request in the cycle a response is consumed (req_ready rises the following cycle).
REQ-028 SHALL ignore req_valid, req_op, req_addr, req_wdata while not IDLE.

Reset
REQ-029 SHALL, on posedge with rst_n=0, enter IDLE and clear rsp_valid, rsp_fault, rsp_rdata, mem_addr, mem_wdata, mem_we to 0; req_ready=1 after reset.
REQ-030 SHALL let reset sampled at the edge ending READ suppress the pending WRITE entirely; a WRITE cycle already in progress completes its negedge commit.

Structure
REQ-031 SHALL place op encodings, state encodings and default MEM_WORDS in shared package mem_pkg.
REQ-032 SHALL isolate lane select/extend and store merge in combinational sub-module mem_lane_align; FSM and registers stay in mem_access_unit.

Verification
REQ-033 SHALL cover: memory word 5 = 0x00000009; LW addr 0x14 -> rsp_valid 2 cycles after accept, rsp_rdata 0x00000009, fault 0.
REQ-034 SHALL cover: word 2 = 0x80FF7F01; LB 0x08 -> 0xFFFFFF80; LBU 0x08 -> 0x00000080; LH 0x0A -> 0x00007F01; LHU 0x08 -> 0x000080FF.
REQ-035 SHALL cover: word 3 = 0x11223344; SB addr 0x0E data 0xAA -> one mem_we pulse, word 3 = 0x1122AA44, rsp_valid 3 cycles after accept.
REQ-036 SHALL cover: LW 0x15, SH 0x03, SW addr 0x80 (MEM_WORDS=32) -> rsp_fault=1 after 1 cycle, mem_we never asserted.
REQ-037 SHALL cover: rsp_ready held 0 for 4 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; rst_n=0 at edge ending READ of SB -> no mem_we, IDLE next cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory access unit: op and state encodings, latched request
// payload and small decode helpers.
package mem_pkg;

  localparam int unsigned DATA_W            = 32;
  localparam int unsigned ADDR_W            = 32;
  localparam int unsigned IDX_W             = ADDR_W - 2;
  localparam int unsigned MEM_WORDS_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_SB  = 3'b011,
    OP_LBU = 3'b100,
    OP_LHU = 3'b101,
    OP_SH  = 3'b110,
    OP_SW  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    op_e               op;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        off;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Sub-word stores need the old word first (read-modify-write).
  function automatic logic is_rmw(input op_e op);
    return (op == OP_SB) || (op == OP_SH);
  endfunction

  function automatic logic misaligned(input op_e op, input logic [1:0] off);
    logic r;
    r = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: r = off[0];
      OP_LW, OP_SW:         r = (off != 2'b00);
      default:              r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane logic: extracts and extends load data, and merges sub-word
// store data into the word read back from memory.
module mem_lane_align
  import mem_pkg::*;
(
  input  op_e               i_op,
  input  logic [1:0]        i_off,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load_data,
  output logic [DATA_W-1:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte offset 0 is the most significant lane.
  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'd0: w_byte = i_rdata[31:24];
      2'd1: w_byte = i_rdata[23:16];
      2'd2: w_byte = i_rdata[15:8];
      2'd3: w_byte = i_rdata[7:0];
      default: w_byte = 8'h00;
    endcase
    w_half = i_off[1] ? i_rdata[15:0] : i_rdata[31:16];
  end

  always_comb begin
    o_load_data = '0;
    case (i_op)
      OP_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_load_data = {24'h000000, w_byte};
      OP_LH:   o_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_load_data = {16'h0000, w_half};
      OP_LW:   o_load_data = i_rdata;
      default: o_load_data = '0;
    endcase
  end

  always_comb begin
    o_merged = i_wdata;
    case (i_op)
      OP_SB: begin
        case (i_off)
          2'd0:    o_merged = {i_wdata[7:0], i_rdata[23:0]};
          2'd1:    o_merged = {i_rdata[31:24], i_wdata[7:0], i_rdata[15:0]};
          2'd2:    o_merged = {i_rdata[31:16], i_wdata[7:0], i_rdata[7:0]};
          default: o_merged = {i_rdata[31:8], i_wdata[7:0]};
        endcase
      end
      OP_SH:   o_merged = i_off[1] ? {i_rdata[31:16], i_wdata[15:0]}
                                   : {i_wdata[15:0], i_rdata[15:0]};
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a single-port word memory: checks alignment and
// range, sequences read/write/read-modify-write and holds the response.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            r_state;
  state_e            w_state_nxt;
  req_t              r_req;

  op_e               w_req_op;
  logic [IDX_W-1:0]  w_req_idx;
  logic              w_req_fault;
  logic [IDX_W-1:0]  w_idx_sel;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_merged;

  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_rsp_fault;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;

  logic              w_req_ready_nxt;
  logic              w_rsp_valid_nxt;
  logic              w_rsp_fault_nxt;
  logic [DATA_W-1:0] w_rsp_rdata_nxt;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [DATA_W-1:0] w_mem_wdata_nxt;
  logic              w_mem_we_nxt;

  assign w_req_op    = op_e'(req_op);
  assign w_req_idx   = req_addr[ADDR_W-1:2];
  assign w_req_fault = misaligned(w_req_op, req_addr[1:0]) ||
                       (ADDR_W'(w_req_idx) >= ADDR_W'(MEM_WORDS));
  assign w_idx_sel   = (r_state == ST_IDLE) ? w_req_idx : r_req.idx;

  mem_lane_align u_lane (
    .i_op        (r_req.op),
    .i_off       (r_req.off),
    .i_rdata     (mem_rdata),
    .i_wdata     (r_req.wdata),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_req_fault)            w_state_nxt = ST_RESP;
          else if (w_req_op == OP_SW) w_state_nxt = ST_WRITE;
          else                        w_state_nxt = ST_READ;
        end
      end
      ST_READ:  w_state_nxt = is_rmw(r_req.op) ? ST_WRITE : ST_RESP;
      ST_WRITE: w_state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the upcoming state.
  always_comb begin
    w_req_ready_nxt = (w_state_nxt == ST_IDLE);
    w_rsp_valid_nxt = (w_state_nxt == ST_RESP);
    w_mem_we_nxt    = (w_state_nxt == ST_WRITE);
    w_mem_addr_nxt  = '0;
    w_mem_wdata_nxt = r_mem_wdata;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_fault_nxt = r_rsp_fault;
    if ((w_state_nxt == ST_READ) || (w_state_nxt == ST_WRITE))
      w_mem_addr_nxt = ADDR_W'(w_idx_sel);
    if ((r_state == ST_IDLE) && (w_state_nxt == ST_WRITE))
      w_mem_wdata_nxt = req_wdata;
    else if ((r_state == ST_READ) && (w_state_nxt == ST_WRITE))
      w_mem_wdata_nxt = w_merged;
    if ((r_state != ST_RESP) && (w_state_nxt == ST_RESP)) begin
      w_rsp_fault_nxt = (r_state == ST_IDLE);
      w_rsp_rdata_nxt = (r_state == ST_READ) ? w_load_data : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
    end else begin
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_fault <= w_rsp_fault_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_we    <= w_mem_we_nxt;
    end
  end

  // Request fields are captured only on acceptance; inputs are ignored otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req <= '0;
    end else if ((r_state == ST_IDLE) && req_valid) begin
      r_req.op    <= w_req_op;
      r_req.idx   <= w_req_idx;
      r_req.off   <= req_addr[1:0];
      r_req.wdata <= req_wdata;
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_fault = r_rsp_fault;
  assign rsp_rdata = r_rsp_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a negedge-commit word memory model.
module tb_mem_access_unit;

  localparam int unsigned NW = 32;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [NW];
  logic [31:0] shadow [NW];
  logic        pl_en;
  logic [4:0]  pl_idx;
  logic [31:0] pl_data;
  int          we_cnt;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
    logic [3:0]  lat;
  } exp_t;
  exp_t sb_q[$];

  int errors;
  int checks;

  mem_access_unit #(.MEM_WORDS(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_fault (rsp_fault),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 32'(NW)) ? mem[mem_addr[4:0]] : 32'h0;

  // Memory commits on the falling edge of the write cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      if (mem_addr < 32'(NW)) mem[mem_addr[4:0]] = mem_wdata;
      we_cnt = we_cnt + 1;
    end else if (pl_en) begin
      mem[pl_idx] = pl_data;
    end
  end

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] w,
                                           input logic [1:0] off);
    logic [31:0] top;
    top = w << (8 * off);
    case (op)
      3'b000:  return 32'($signed(top) >>> 24);
      3'b100:  return top >> 24;
      3'b001:  return 32'($signed(top) >>> 16);
      3'b101:  return top >> 16;
      3'b010:  return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [2:0] op, input logic [31:0] w,
                                            input logic [31:0] d, input logic [1:0] off);
    logic [31:0] mask;
    logic [31:0] lane;
    if (op == 3'b111) return d;
    mask = (op == 3'b011) ? (32'hFF00_0000 >> (8 * off)) : (32'hFFFF_0000 >> (8 * off));
    lane = (op == 3'b011) ? ({d[7:0], 24'h0} >> (8 * off)) : ({d[15:0], 16'h0} >> (8 * off));
    return (w & ~mask) | (lane & mask);
  endfunction

  task automatic preload(input int idx, input logic [31:0] d);
    @(posedge clk);
    #1;
    pl_en = 1'b1; pl_idx = 5'(idx); pl_data = d;
    shadow[idx] = d;
    @(negedge clk);
    #1;
    pl_en = 1'b0;
  endtask

  // Drives one request, compares the response against the popped expectation.
  task automatic txn(input string nm, input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] erd, input logic ef,
                     input int elat, input int hold);
    exp_t e;
    int   lat;
    bit   got;
    logic [31:0] first;
    e.rdata = erd; e.fault = ef; e.lat = 4'(elat);
    sb_q.push_back(e);
    lat = 0;
    while (!req_ready && lat < 20) begin @(negedge clk); lat++; end
    if (!req_ready) begin
      errors++; checks++;
      $display("FAIL %s: req_ready never rose", nm);
      void'(sb_q.pop_front());
      return;
    end
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 3'($urandom_range(0, 7));
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 0; got = 1'b0;
    while (lat < 10 && !got) begin @(negedge clk); lat++; got = rsp_valid; end
    e = sb_q.pop_front();
    checks++;
    if (!got || lat !== int'(e.lat)) begin
      errors++;
      $display("FAIL %s latency: got %0d (valid=%0b) expected %0d", nm, lat, got, e.lat);
    end
    checks++;
    if (rsp_rdata !== e.rdata) begin
      errors++;
      $display("FAIL %s rdata: got %h expected %h", nm, rsp_rdata, e.rdata);
    end
    checks++;
    if (rsp_fault !== e.fault) begin
      errors++;
      $display("FAIL %s fault: got %b expected %b", nm, rsp_fault, e.fault);
    end
    first = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== first || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d: valid=%b rdata=%h ready=%b expected 1 %h 0",
                 nm, i, rsp_valid, rsp_rdata, req_ready, first);
      end
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_in_resp: got %b expected 0", nm, req_ready);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s after_consume: ready=%b valid=%b expected 1 0", nm, req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1)  begin errors++; $display("FAIL reset req_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0)  begin errors++; $display("FAIL reset rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_fault !== 1'b0)  begin errors++; $display("FAIL reset rsp_fault: got %b expected 0", rsp_fault); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset rsp_rdata: got %h expected 0", rsp_rdata); end
    checks++; if (mem_addr !== 32'h0)  begin errors++; $display("FAIL reset mem_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset mem_wdata: got %h expected 0", mem_wdata); end
    checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL reset mem_we: got %b expected 0", mem_we); end
  endtask

  task automatic test_lw();
    preload(5, 32'h0000_0009);
    txn("lw_0x14", 3'b010, 32'h14, 32'h0, 32'h0000_0009, 1'b0, 2, 0);
  endtask

  task automatic test_loads();
    preload(2, 32'h80FF_7F01);
    txn("lb_0x08",  3'b000, 32'h08, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0);
    txn("lbu_0x08", 3'b100, 32'h08, 32'h0, 32'h0000_0080, 1'b0, 2, 0);
    txn("lh_0x0a",  3'b001, 32'h0A, 32'h0, 32'h0000_7F01, 1'b0, 2, 0);
    txn("lhu_0x08", 3'b101, 32'h08, 32'h0, 32'h0000_80FF, 1'b0, 2, 0);
  endtask

  task automatic test_store_sb();
    int w0;
    preload(3, 32'h1122_3344);
    w0 = we_cnt;
    txn("sb_0x0e", 3'b011, 32'h0E, 32'h0000_00AA, 32'h0, 1'b0, 3, 0);
    checks++;
    if (we_cnt - w0 !== 1) begin errors++; $display("FAIL sb we_pulses: got %0d expected 1", we_cnt - w0); end
    checks++;
    if (mem[3] !== 32'h1122_AA44) begin errors++; $display("FAIL sb word3: got %h expected 1122aa44", mem[3]); end
  endtask

  task automatic test_faults();
    int w0;
    w0 = we_cnt;
    txn("flt_lw_0x15", 3'b010, 32'h15, 32'h0, 32'h0, 1'b1, 1, 0);
    txn("flt_sh_0x03", 3'b110, 32'h03, 32'hBEEF, 32'h0, 1'b1, 1, 0);
    txn("flt_sw_0x80", 3'b111, 32'h80, 32'h1234_5678, 32'h0, 1'b1, 1, 0);
    checks++;
    if (we_cnt != w0) begin errors++; $display("FAIL faults mem_we: got %0d pulses expected 0", we_cnt - w0); end
  endtask

  task automatic test_hold();
    preload(7, 32'hDEAD_BEEF);
    txn("hold_lw", 3'b010, 32'h1C, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 4);
  endtask

  task automatic test_reset_rmw();
    int w0;
    preload(4, 32'hCAFE_BABE);
    w0 = we_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b011; req_addr = 32'h11; req_wdata = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_rmw state: we=%b ready=%b valid=%b expected 0 1 0", mem_we, req_ready, rsp_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (we_cnt != w0 || mem[4] !== 32'hCAFE_BABE) begin
      errors++;
      $display("FAIL rst_rmw write: pulses=%0d word=%h expected 0 cafebabe", we_cnt - w0, mem[4]);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [1:0]  off;
    int          idx;
    logic        flt;
    logic        st;
    logic [31:0] wd;
    logic [31:0] erd;
    int          lat;
    for (int n = 0; n < 16; n++) begin
      op  = 3'($urandom_range(0, 7));
      off = 2'($urandom_range(0, 3));
      idx = ($urandom_range(0, 7) == 0) ? 40 : $urandom_range(8, 15);
      wd  = $urandom;
      st  = (op == 3'b011) || (op == 3'b110) || (op == 3'b111);
      flt = (idx >= int'(NW)) ||
            (((op == 3'b001) || (op == 3'b101) || (op == 3'b110)) && off[0]) ||
            (((op == 3'b010) || (op == 3'b111)) && (off != 2'b00));
      lat = flt ? 1 : (op == 3'b111) ? 2 : st ? 3 : 2;
      erd = (flt || st) ? 32'h0 : ref_load(op, shadow[idx], off);
      txn($sformatf("rnd%0d", n), op, {30'(idx), off}, wd, erd, flt, lat, 0);
      if (st && !flt) begin
        shadow[idx] = ref_store(op, shadow[idx], wd, off);
        checks++;
        if (mem[idx] !== shadow[idx]) begin
          errors++;
          $display("FAIL rnd%0d store word%0d: got %h expected %h", n, idx, mem[idx], shadow[idx]);
        end
      end
    end
  endtask

  initial begin
    errors = 0; checks = 0; we_cnt = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    rsp_ready = 1'b0; pl_en = 1'b0; pl_idx = 5'd0; pl_data = 32'h0;
    for (int i = 0; i < int'(NW); i++) begin
      mem[i] = 32'h0;
      shadow[i] = 32'h0;
    end
    test_reset();
    for (int i = 8; i < 16; i++) preload(i, $urandom);
    test_lw();
    test_loads();
    test_store_sb();
    test_faults();
    test_hold();
    test_reset_rmw();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
